// File: rtl/hqm_aw_sync_edge_filter.sv
//------------------------------------------------------------------------------
// hqm_aw_sync_edge_filter
//
// Purpose:
//   Debounces WIDTH already-synchronized level inputs. It produces one-cycle
//   rise/fall pulses on each change of the filtered level. Each edge is latched
//   into a pending-event register that a consumer drains with a valid/ready
//   handshake. An optional saturating counter counts the cycles in which any
//   edge occurred.
//
// Handshake:
//   - evt_valid is high while any pending flag is set.
//   - A transfer happens on a cycle where evt_valid and evt_ready are both
//     high. It clears all pending flags and evt_ovf.
//   - While evt_valid=1 and evt_ready=0, the payload is held. Newly arriving
//     flags may only be OR'd in.
//   - evt_ready while evt_valid=0 is ignored.
//
// Configuration macro:
//   HQM_AW_SYNC_EDGE_FILTER_CNT_EN
//     - Defined: evt_cnt is a saturating CNTW-bit counter.
//     - Undefined: evt_cnt is tied to 0 and clr_cnt is ignored.
//
// Ports:
//   clk         in   1      rising-edge clock (synchronizer domain)
//   rst_n       in   1      asynchronous active-low reset
//   data_sync   in   WIDTH  synchronized input levels
//   filt_level  out  WIDTH  debounced levels
//   rise_pulse  out  WIDTH  one-cycle pulse on 0->1 of filt_level
//   fall_pulse  out  WIDTH  one-cycle pulse on 1->0 of filt_level
//   evt_valid   out  1      a pending event is available
//   evt_ready   in   1      consumer accepts the pending event
//   evt_rise    out  WIDTH  pending rise flags
//   evt_fall    out  WIDTH  pending fall flags
//   evt_ovf     out  1      sticky: an edge hit an already-set pending flag
//   clr_cnt     in   1      synchronous clear of evt_cnt
//   evt_cnt     out  CNTW   saturating count of edge cycles
//------------------------------------------------------------------------------
module hqm_aw_sync_edge_filter #(
   parameter int WIDTH    = 1,
   parameter int DEBOUNCE = 2,
   parameter int CNTW     = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] data_sync,
   output logic [WIDTH-1:0] filt_level,
   output logic [WIDTH-1:0] rise_pulse,
   output logic [WIDTH-1:0] fall_pulse,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic [WIDTH-1:0] evt_rise,
   output logic [WIDTH-1:0] evt_fall,
   output logic             evt_ovf,
   input  logic             clr_cnt,
   output logic [CNTW-1:0]  evt_cnt
);

   // The counter value at which the next differing sample is the DEBOUNCE-th.
   localparam logic [3:0] DB_LAST = 4'(DEBOUNCE - 1);

   logic [3:0]       r_db_cnt [WIDTH];
   logic [3:0]       w_db_cnt_nxt [WIDTH];
   logic [WIDTH-1:0] w_toggle;

   logic [WIDTH-1:0] r_filt;
   logic [WIDTH-1:0] r_rise;
   logic [WIDTH-1:0] r_fall;
   logic [WIDTH-1:0] r_pend_rise;
   logic [WIDTH-1:0] r_pend_fall;
   logic             r_ovf;

   logic             w_valid;
   logic             w_hs;
   logic             w_lost;
   logic             w_any_edge;

   // Debounce: count consecutive samples that differ from the filtered level.
   // On the DEBOUNCE-th such sample, flip the level and restart the count.
   always_comb begin
      w_toggle = '0;
      for (int i = 0; i < WIDTH; i++) begin
         w_db_cnt_nxt[i] = 4'd0;
         if (data_sync[i] != r_filt[i]) begin
            if (r_db_cnt[i] == DB_LAST) begin
               w_toggle[i] = 1'b1;
            end else begin
               w_db_cnt_nxt[i] = r_db_cnt[i] + 4'd1;
            end
         end
      end
   end

   assign w_valid    = |(r_pend_rise | r_pend_fall);
   assign w_hs       = w_valid & evt_ready;
   assign w_any_edge = |(r_rise | r_fall);
   // An edge is lost when its flag is already pending and no transfer
   // frees the flag this cycle.
   assign w_lost     = |((r_rise & r_pend_rise) | (r_fall & r_pend_fall));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < WIDTH; i++) begin
            r_db_cnt[i] <= 4'd0;
         end
         r_filt      <= '0;
         r_rise      <= '0;
         r_fall      <= '0;
         r_pend_rise <= '0;
         r_pend_fall <= '0;
         r_ovf       <= 1'b0;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            r_db_cnt[i] <= w_db_cnt_nxt[i];
         end
         r_filt <= r_filt ^ w_toggle;
         // Pulses are registered alongside the level, so each pulse lines up
         // with the first cycle that shows the new level.
         r_rise <= w_toggle & ~r_filt;
         r_fall <= w_toggle &  r_filt;
         // A transfer clears the flags first. A pulse in the same cycle is
         // then loaded into the cleared flags, so the new event survives.
         r_pend_rise <= (w_hs ? '0 : r_pend_rise) | r_rise;
         r_pend_fall <= (w_hs ? '0 : r_pend_fall) | r_fall;
         r_ovf       <= w_hs ? 1'b0 : (r_ovf | w_lost);
      end
   end

   assign filt_level = r_filt;
   assign rise_pulse = r_rise;
   assign fall_pulse = r_fall;
   assign evt_valid  = w_valid;
   assign evt_rise   = r_pend_rise;
   assign evt_fall   = r_pend_fall;
   assign evt_ovf    = r_ovf;

`ifdef HQM_AW_SYNC_EDGE_FILTER_CNT_EN
   logic [CNTW-1:0] r_evt_cnt;

   // Saturating counter: clear has priority over a same-cycle increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_evt_cnt <= '0;
      end else if (clr_cnt) begin
         r_evt_cnt <= '0;
      end else if (w_any_edge && (r_evt_cnt != {CNTW{1'b1}})) begin
         r_evt_cnt <= r_evt_cnt + 1'b1;
      end
   end

   assign evt_cnt = r_evt_cnt;
`else
   logic w_unused_cnt;

   assign w_unused_cnt = clr_cnt | w_any_edge;
   assign evt_cnt      = '0;
`endif

endmodule

// File: tb/tb_hqm_aw_sync_edge_filter.sv
module tb_hqm_aw_sync_edge_filter;

  localparam int WIDTH    = 2;
  localparam int DEBOUNCE = 3;
  localparam int CNTW     = 2;
  localparam int OW       = 14;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] data_sync;
  logic [WIDTH-1:0] filt_level;
  logic [WIDTH-1:0] rise_pulse;
  logic [WIDTH-1:0] fall_pulse;
  logic             evt_valid;
  logic             evt_ready;
  logic [WIDTH-1:0] evt_rise;
  logic [WIDTH-1:0] evt_fall;
  logic             evt_ovf;
  logic             clr_cnt;
  logic [CNTW-1:0]  evt_cnt;

  int n_checks;
  int n_errors;

  typedef struct {
    logic [1:0]    d;
    logic          rdy;
    logic          clr;
    logic [OW-1:0] exp;
  } vec_t;

  vec_t vecs[$];

  hqm_aw_sync_edge_filter #(
    .WIDTH(WIDTH), .DEBOUNCE(DEBOUNCE), .CNTW(CNTW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .data_sync(data_sync),
    .filt_level(filt_level), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_rise(evt_rise), .evt_fall(evt_fall), .evt_ovf(evt_ovf),
    .clr_cnt(clr_cnt), .evt_cnt(evt_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected-output packing: {filt, rise, fall, valid, erise, efall, ovf, cnt}.
  // Counter expectation only applies when the counter is built in.
  function automatic logic [OW-1:0] mk_exp(logic [1:0] filt, logic [1:0] rise,
                                           logic [1:0] fall, logic v,
                                           logic [1:0] er, logic [1:0] ef,
                                           logic ovf, logic [1:0] cnt);
    logic [1:0] c;
`ifdef HQM_AW_SYNC_EDGE_FILTER_CNT_EN
    c = cnt;
`else
    c = 2'd0;
`endif
    return {filt, rise, fall, v, er, ef, ovf, c};
  endfunction

  function automatic logic [OW-1:0] dut_out();
    return {filt_level, rise_pulse, fall_pulse, evt_valid,
            evt_rise, evt_fall, evt_ovf, evt_cnt};
  endfunction

  task automatic check(input string name, input logic [OW-1:0] exp);
    logic [OW-1:0] got;
    got = dut_out();
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h (filt,rise,fall,v,erise,efall,ovf,cnt)",
               name, got, exp);
    end
  endtask

  // driver: apply inputs, take one active edge, sample 1ns later
  task automatic step(input logic [1:0] d, input logic rdy, input logic clr);
    data_sync = d;
    evt_ready = rdy;
    clr_cnt   = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [1:0] d, input logic rdy, input logic clr,
                     input logic [1:0] filt, input logic [1:0] rise,
                     input logic [1:0] fall, input logic v,
                     input logic [1:0] er, input logic [1:0] ef,
                     input logic ovf, input logic [1:0] cnt);
    vec_t r;
    r.d   = d;
    r.rdy = rdy;
    r.clr = clr;
    r.exp = mk_exp(filt, rise, fall, v, er, ef, ovf, cnt);
    vecs.push_back(r);
  endtask

  initial begin
    vec_t r;
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    data_sync = 2'b00;
    evt_ready = 1'b0;
    clr_cnt   = 1'b0;

    //   d     rdy   clr   filt   rise   fall   v     erise  efall  ovf   cnt
    // bit0 rises: level changes on the 3rd edge, event visible one cycle later
    add(2'b01, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 2'd0);
    add(2'b01, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 2'd0);
    add(2'b01, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 2'd0);
    add(2'b01, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b1, 2'b01, 2'b00, 1'b0, 2'd1);
    // bit1 glitch of 2 samples: filtered out; payload held while ready=0
    add(2'b11, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b1, 2'b01, 2'b00, 1'b0, 2'd1);
    add(2'b11, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b1, 2'b01, 2'b00, 1'b0, 2'd1);
    add(2'b01, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b1, 2'b01, 2'b00, 1'b0, 2'd1);
    add(2'b01, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b1, 2'b01, 2'b00, 1'b0, 2'd1);
    // consume, then ready with nothing pending
    add(2'b01, 1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 2'd1);
    add(2'b01, 1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 2'd1);
    // bit0 falls, consumed
    add(2'b00, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 2'd1);
    add(2'b00, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 2'd1);
    add(2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 1'b0, 2'b00, 2'b00, 1'b0, 2'd1);
    add(2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 2'b01, 1'b0, 2'd2);
    add(2'b01, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 2'd2);
    // two rises on bit0 with ready=0: second one sets ovf; counter saturates
    add(2'b01, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 2'd2);
    add(2'b01, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 2'd2);
    add(2'b01, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b1, 2'b01, 2'b00, 1'b0, 2'd3);
    add(2'b00, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b1, 2'b01, 2'b00, 1'b0, 2'd3);
    add(2'b00, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b1, 2'b01, 2'b00, 1'b0, 2'd3);
    add(2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 1'b1, 2'b01, 2'b00, 1'b0, 2'd3);
    add(2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 2'b01, 2'b01, 1'b0, 2'd3);
    add(2'b01, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 2'b01, 2'b01, 1'b0, 2'd3);
    add(2'b01, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 2'b01, 2'b01, 1'b0, 2'd3);
    add(2'b01, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 1'b1, 2'b01, 2'b01, 1'b0, 2'd3);
    add(2'b01, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b1, 2'b01, 2'b01, 1'b1, 2'd3);
    // one-cycle ready clears everything including ovf
    add(2'b01, 1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 2'd3);
    // counter clear alone
    add(2'b01, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 2'd0);
    // bit1 rise pending, then ready in the same cycle as the bit1 fall pulse
    add(2'b11, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 2'd0);
    add(2'b11, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 2'd0);
    add(2'b11, 1'b0, 1'b0, 2'b11, 2'b10, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 2'd0);
    add(2'b11, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 1'b1, 2'b10, 2'b00, 1'b0, 2'd1);
    add(2'b01, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 1'b1, 2'b10, 2'b00, 1'b0, 2'd1);
    add(2'b01, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 1'b1, 2'b10, 2'b00, 1'b0, 2'd1);
    add(2'b01, 1'b0, 1'b0, 2'b01, 2'b00, 2'b10, 1'b1, 2'b10, 2'b00, 1'b0, 2'd1);
    // the new fall wins; clr with a simultaneous edge gives 0
    add(2'b01, 1'b1, 1'b1, 2'b01, 2'b00, 2'b00, 1'b1, 2'b00, 2'b10, 1'b0, 2'd0);
    add(2'b01, 1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 2'd0);

    // reset state
    @(posedge clk);
    #1;
    check("reset_state", '0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      r = vecs[i];
      step(r.d, r.rdy, r.clr);
      check($sformatf("vec%0d", i), r.exp);
    end

    // reset while an event is pending: outputs drop at once, nothing after
    step(2'b00, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b0);
    check("pre_reset_valid",
          mk_exp(2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 2'b01, 1'b0, 2'd1));
    rst_n = 1'b0;
    #1;
    check("async_reset", '0);
    step(2'b00, 1'b1, 1'b0);
    step(2'b00, 1'b1, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(2'b00, 1'b0, 1'b0);
      check($sformatf("post_reset_quiet%0d", i), '0);
    end

    // release reset with data high: rise after DEBOUNCE samples
    rst_n = 1'b0;
    step(2'b01, 1'b0, 1'b0);
    check("reset_hold", '0);
    rst_n = 1'b1;
    step(2'b01, 1'b0, 1'b0);
    check("rel_edge1", '0);
    step(2'b01, 1'b0, 1'b0);
    check("rel_edge2", '0);
    step(2'b01, 1'b0, 1'b0);
    check("rel_edge3",
          mk_exp(2'b01, 2'b01, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 2'd0));
    step(2'b01, 1'b0, 1'b0);
    check("rel_edge4",
          mk_exp(2'b01, 2'b00, 2'b00, 1'b1, 2'b01, 2'b00, 1'b0, 2'd1));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/hqm_aw_sync_edge_filter.md
HQM_AW_SYNC_EDGE_FILTER -- requirements
Module: hqm_aw_sync_edge_filter

Interface
REQ-001 Parameter WIDTH, default 1: number of independent synchronized input bits.
REQ-002 Parameter DEBOUNCE, default 2, legal 1..15: consecutive differing samples required before the filtered level changes.
REQ-003 Parameter CNTW, default 8, legal 1..32: event counter width.
REQ-004 clk  input  1  block clock, rising-edge active; the same domain as the upstream synchronizer output.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 data_sync  input  WIDTH  synchronized level from the 2-flop synchronizer stage.
REQ-007 filt_level  output  WIDTH  debounced level per bit.
REQ-008 rise_pulse  output  WIDTH  one-cycle pulse on each 0->1 filt_level change.
REQ-009 fall_pulse  output  WIDTH  one-cycle pulse on each 1->0 filt_level change.
REQ-010 evt_valid  output  1  pending event available.
REQ-011 evt_ready  input  1  consumer accepts the event.
REQ-012 evt_rise / evt_fall  output  WIDTH each  pending rise/fall flags per bit (event payload).
REQ-013 evt_ovf  output  1  an edge was lost while its pending flag was still set.
REQ-014 clr_cnt  input  1  synchronous event counter clear.
REQ-015 evt_cnt  output  CNTW  saturating count of edge cycles.

Function
REQ-016 Each bit shall have a debounce counter: it resets to 0 when data_sync[i]==filt_level[i] and increments when they differ.
REQ-017 filt_level[i] shall toggle on the clock edge at which data_sync[i] has differed for DEBOUNCE consecutive samples, and the counter shall return to 0 on that edge.
REQ-018 DEBOUNCE=1 shall give a one-cycle delayed copy; a differing run shorter than DEBOUNCE shall cause no change.
REQ-019 rise_pulse[i]/fall_pulse[i] shall be registered and high only in the first cycle filt_level[i] shows its new value.
REQ-020 pend_rise[i]/pend_fall[i] shall set on the cycle after the corresponding pulse is high; evt_valid = OR of all pending flags; evt_rise = pend_rise; evt_fall = pend_fall.
REQ-021 Handshake: on evt_valid&evt_ready, all pending flags and evt_ovf shall clear; a pulse in the same cycle shall load into the freshly cleared flags (the new event wins).
REQ-022 A pulse arriving while its pending flag is set and no handshake occurs shall set evt_ovf sticky.
REQ-023 evt_valid, evt_rise, evt_fall and evt_ovf shall remain stable while evt_valid=1 and evt_ready=0, except that new flags may be OR'd in.
REQ-024 evt_ready while evt_valid=0 shall have no effect.
REQ-025 evt_cnt shall increment by 1 in each cycle where any rise_pulse or fall_pulse bit is high, regardless of how many bits are high.
REQ-026 evt_cnt shall saturate at 2^CNTW-1 and shall never wrap.
REQ-027 clr_cnt shall force evt_cnt to 0 on the next edge; clr_cnt with a simultaneous increment shall yield 0.

Reset
REQ-028 While rst_n=0, all outputs shall be 0, and all debounce counters, pending flags and evt_ovf shall be 0.
REQ-029 On release with data_sync=1, rise_pulse shall occur after DEBOUNCE differing samples.
REQ-030 Reset mid-handshake shall discard pending events without further output.

Configuration
REQ-031 With macro HQM_AW_SYNC_EDGE_FILTER_CNT_EN defined, the counter of REQ-025..REQ-027 shall be implemented.
REQ-032 With HQM_AW_SYNC_EDGE_FILTER_CNT_EN undefined, the evt_cnt port shall still exist and be tied to 0, clr_cnt shall be ignored, and no counter flops shall be present.

Verification
REQ-033 DEBOUNCE=3, data_sync[0] 0->1 held -> filt_level[0]=1 at the third edge after the change; rise_pulse[0] high exactly 1 cycle; evt_valid=1 the next cycle.
REQ-034 DEBOUNCE=3, data_sync[0] high for 2 cycles then low -> no filt_level, pulse or evt_valid activity.
REQ-035 evt_ready=0, two rises on bit 0 -> evt_rise[0]=1, evt_ovf=1; assert evt_ready for 1 cycle -> evt_valid=0, evt_ovf=0.
REQ-036 evt_ready=1 in the same cycle as a new fall_pulse[1] -> the old event is consumed and the next cycle shows evt_valid=1 with evt_fall[1]=1.
REQ-037 CNTW=2 with macro defined, 5 edge cycles -> evt_cnt=3; clr_cnt together with an edge -> evt_cnt=0. Macro undefined -> evt_cnt=0 throughout.
REQ-038 rst_n asserted while evt_valid=1 -> all outputs 0 immediately; after release with data_sync=0, no event is reported.
